// File: rtl/runner_sample_gen.sv
// Runner sample generator: turns step and heartbeat levels into a once-per-second
// sample of steps, stride and heart rate for the step calculator.
module runner_sample_gen #(
  parameter int TICKS_PER_SEC  = 100,
  parameter int MAX_SILENT_SEC = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       step_pulse,
  input  logic       beat_pulse,
  input  logic [7:0] stride_cfg,
  output logic [7:0] hr_input,
  output logic [1:0] steps_per_second,
  output logic [7:0] stride_length,
  output logic       valid_input,
  output logic       div_busy
);

  localparam logic [15:0] WIN_LAST   = 16'(TICKS_PER_SEC - 1);
  localparam logic [15:0] SAT_VAL    = 16'(MAX_SILENT_SEC * TICKS_PER_SEC);
  localparam logic [15:0] SAT_PRE    = 16'(MAX_SILENT_SEC * TICKS_PER_SEC - 1);
  localparam logic [15:0] GLITCH_MIN = 16'(TICKS_PER_SEC / 5);
  localparam logic [31:0] DIVIDEND   = 32'(60 * TICKS_PER_SEC);

  typedef enum logic [1:0] {D_IDLE, D_BUSY, D_DONE} div_state_t;

  div_state_t  state;
  div_state_t  next_state;

  logic [15:0] win_cnt;
  logic [1:0]  step_cnt;
  logic        step_prev;
  logic        beat_prev;
  logic [15:0] int_cnt;
  logic        armed;
  logic [15:0] divisor;
  logic [4:0]  iter;
  logic [15:0] rem;
  logic [31:0] quo;
  logic [7:0]  bpm_reg;

  logic        step_edge;
  logic        beat_edge;
  logic        win_end;
  logic        beat_ok;
  logic        div_start;
  logic        sat_hit;
  logic [1:0]  steps_next;
  logic [16:0] trial;
  logic        trial_ge;
  logic [15:0] rem_next;
  logic [31:0] quo_next;
  logic [7:0]  quo_clamp;

  // Event decoding: edges, window end, beat acceptance and silence timeout
  always_comb begin
    step_edge  = step_pulse & ~step_prev;
    beat_edge  = beat_pulse & ~beat_prev;
    win_end    = enable && (win_cnt == WIN_LAST);
    beat_ok    = enable && beat_edge && (int_cnt >= GLITCH_MIN);
    div_start  = beat_ok && armed;
    sat_hit    = enable && !beat_ok && (int_cnt == SAT_PRE);
    steps_next = step_cnt;
    if (step_edge && step_cnt != 2'd3) begin
      steps_next = step_cnt + 2'd1;
    end
  end

  // One restoring-division step plus the clamped quotient for the bpm register
  always_comb begin
    trial     = {rem, quo[31]};
    trial_ge  = trial >= {1'b0, divisor};
    rem_next  = trial_ge ? 16'(trial - {1'b0, divisor}) : trial[15:0];
    quo_next  = {quo[30:0], trial_ge};
    quo_clamp = (|quo[31:8]) ? 8'hFF : quo[7:0];
  end

  // Divider next-state: aborts and restarts take priority over normal progress
  always_comb begin
    next_state = state;
    if (!enable || sat_hit) begin
      next_state = D_IDLE;
    end else if (div_start) begin
      next_state = D_BUSY;
    end else begin
      case (state)
        D_BUSY:  if (iter == 5'd31) next_state = D_DONE;
        D_DONE:  next_state = D_IDLE;
        default: next_state = state;
      endcase
    end
  end

  // Divider state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= D_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Divider datapath and bpm register
  always_ff @(posedge clk) begin
    if (rst) begin
      divisor <= '0;
      iter    <= '0;
      rem     <= '0;
      quo     <= '0;
      bpm_reg <= '0;
    end else begin
      if (div_start) begin
        divisor <= int_cnt;
        iter    <= '0;
        rem     <= '0;
        quo     <= DIVIDEND;
      end else if (state == D_BUSY) begin
        iter <= iter + 5'd1;
        rem  <= rem_next;
        quo  <= quo_next;
      end
      if (sat_hit) begin
        bpm_reg <= '0;
      end else if (enable && state == D_DONE) begin
        bpm_reg <= quo_clamp;
      end
    end
  end

  // Window, step and beat-interval counting plus the sample output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      step_prev        <= 1'b0;
      beat_prev        <= 1'b0;
      win_cnt          <= '0;
      step_cnt         <= '0;
      int_cnt          <= '0;
      armed            <= 1'b0;
      valid_input      <= 1'b0;
      hr_input         <= '0;
      steps_per_second <= '0;
      stride_length    <= '0;
    end else begin
      step_prev <= step_pulse;
      beat_prev <= beat_pulse;
      if (!enable) begin
        win_cnt     <= '0;
        step_cnt    <= '0;
        int_cnt     <= '0;
        armed       <= 1'b0;
        valid_input <= 1'b0;
      end else begin
        valid_input <= win_end;
        if (win_end) begin
          win_cnt          <= '0;
          step_cnt         <= '0;
          steps_per_second <= steps_next;
          stride_length    <= stride_cfg;
          hr_input         <= bpm_reg;
        end else begin
          win_cnt  <= win_cnt + 16'd1;
          step_cnt <= steps_next;
        end
        if (beat_ok) begin
          int_cnt <= 16'd1;
          armed   <= 1'b1;
        end else if (int_cnt != SAT_VAL) begin
          int_cnt <= int_cnt + 16'd1;
        end
        if (sat_hit) begin
          armed <= 1'b0;
        end
      end
    end
  end

  assign div_busy = (state == D_BUSY);

endmodule

// File: tb/tb_runner_sample_gen.sv
// Testbench for runner_sample_gen: directed scenarios plus random traffic,
// checked every cycle against a timestamp-based behavioural model.
module tb_runner_sample_gen;

  localparam int T      = 100;
  localparam int SAT    = 300;
  localparam int GLITCH = T / 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b1;
  logic       step_pulse = 1'b0;
  logic       beat_pulse = 1'b0;
  logic [7:0] stride_cfg = 8'd0;
  logic [7:0] hr_input;
  logic [1:0] steps_per_second;
  logic [7:0] stride_length;
  logic       valid_input;
  logic       div_busy;

  int nCompared = 0;
  int nMismatched = 0;

  runner_sample_gen #(.TICKS_PER_SEC(T), .MAX_SILENT_SEC(3)) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .step_pulse(step_pulse),
    .beat_pulse(beat_pulse),
    .stride_cfg(stride_cfg),
    .hr_input(hr_input),
    .steps_per_second(steps_per_second),
    .stride_length(stride_length),
    .valid_input(valid_input),
    .div_busy(div_busy)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    nCompared++;
    if (actual != expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  task automatic giveBeat();
    beat_pulse = 1'b1;
    applyStimulus(1);
    beat_pulse = 1'b0;
  endtask

  task automatic giveSteps(input int n);
    for (int i = 0; i < n; i++) begin
      step_pulse = 1'b1;
      applyStimulus(1);
      step_pulse = 1'b0;
      applyStimulus(1);
    end
  endtask

  task automatic waitValid(input string name);
    int k;
    k = 0;
    do begin
      applyStimulus(1);
      k++;
    end while (!valid_input && k < 250);
    if (!valid_input) checkOutput({name, "_timeout"}, 0, 1);
  endtask

  // Behavioural model: timestamps of edges instead of counters
  int cyc = 0, n0 = 0, refE = 0, doneE = 0, pendVal = 0, bpmM = 0, stepCnt = 0;
  int hrM = 0, spsM = 0, strideM = 0;
  bit validM = 0, busyM = 0, armed = 0, pend = 0, stepPrev = 0, beatPrev = 0, modelOn = 0;

  // Advance the model on every rising edge, then compare just after it
  always @(posedge clk) begin : model
    bit se, be;
    int iv;
    cyc++;
    se = step_pulse && !stepPrev;
    be = beat_pulse && !beatPrev;
    stepPrev = step_pulse;
    beatPrev = beat_pulse;
    if (rst) begin
      modelOn = 1; stepPrev = 0; beatPrev = 0;
      hrM = 0; spsM = 0; strideM = 0; validM = 0; bpmM = 0;
      stepCnt = 0; armed = 0; pend = 0; n0 = cyc + 1; refE = cyc + 1;
    end else if (!enable) begin
      validM = 0; stepCnt = 0; armed = 0; pend = 0; n0 = cyc + 1; refE = cyc + 1;
    end else begin
      iv = cyc - refE;
      if (iv > SAT) iv = SAT;
      if (se && stepCnt < 3) stepCnt++;
      validM = ((cyc - n0) % T == T - 1);
      if (validM) begin
        hrM = bpmM; spsM = stepCnt; strideM = stride_cfg; stepCnt = 0;
      end
      if (pend && cyc == doneE) begin
        bpmM = pendVal; pend = 0;
      end
      if (be && iv >= GLITCH) begin
        if (armed) begin
          pend = 1; doneE = cyc + 33;
          pendVal = (6000 / iv > 255) ? 255 : 6000 / iv;
        end
        armed = 1; refE = cyc;
      end else if (iv == SAT - 1) begin
        bpmM = 0; armed = 0; pend = 0;
      end
    end
    busyM = pend && (cyc <= doneE - 2);
    #1;
    if (modelOn) begin
      checkOutput("model_hr_input", hr_input, hrM);
      checkOutput("model_steps", steps_per_second, spsM);
      checkOutput("model_stride", stride_length, strideM);
      checkOutput("model_valid", valid_input, validM);
      checkOutput("model_busy", div_busy, busyM);
    end
  end

  // Directed scenarios followed by random traffic
  initial begin
    int k;
    bit seen100, seen240;

    rst = 1'b1; enable = 1'b1;
    applyStimulus(2);
    checkOutput("rst_hr", hr_input, 0);
    checkOutput("rst_steps", steps_per_second, 0);
    checkOutput("rst_stride", stride_length, 0);
    checkOutput("rst_valid", valid_input, 0);
    checkOutput("rst_busy", div_busy, 0);
    rst = 1'b0;
    k = 0;
    do begin
      applyStimulus(1);
      k++;
    end while (!valid_input && k < 150);
    checkOutput("first_valid_edge", k, 100);
    checkOutput("first_valid_hr", hr_input, 0);
    checkOutput("first_valid_steps", steps_per_second, 0);

    // Beats 50 cycles apart give 120 bpm after a 32-cycle division
    giveBeat();
    applyStimulus(49);
    giveBeat();
    k = 0;
    while (div_busy && k < 100) begin
      k++;
      applyStimulus(1);
    end
    checkOutput("busy_cycles", k, 32);
    applyStimulus(1);
    checkOutput("bpm_reg_120", dut.bpm_reg, 120);
    applyStimulus(2);
    waitValid("hr120");
    checkOutput("hr_120", hr_input, 120);

    // Step counting and stride capture
    stride_cfg = 8'd75;
    waitValid("align");
    giveSteps(2);
    waitValid("steps2");
    checkOutput("steps_2", steps_per_second, 2);
    checkOutput("stride_75", stride_length, 75);
    giveSteps(5);
    waitValid("steps5");
    checkOutput("steps_sat_3", steps_per_second, 3);

    // Glitch rejection, then silence drives heart rate to zero
    giveBeat();
    applyStimulus(49);
    giveBeat();
    applyStimulus(9);
    giveBeat();
    applyStimulus(30);
    waitValid("glitch");
    checkOutput("hr_after_glitch", hr_input, 120);
    applyStimulus(300);
    waitValid("silence");
    checkOutput("hr_silence_0", hr_input, 0);

    // Reset during division, then 40-cycle beats give 150 bpm
    giveBeat();
    applyStimulus(49);
    giveBeat();
    applyStimulus(5);
    rst = 1'b1;
    applyStimulus(1);
    checkOutput("midrst_busy", div_busy, 0);
    checkOutput("midrst_hr", hr_input, 0);
    checkOutput("midrst_steps", steps_per_second, 0);
    checkOutput("midrst_stride", stride_length, 0);
    checkOutput("midrst_valid", valid_input, 0);
    rst = 1'b0;
    applyStimulus(25);
    for (int i = 0; i < 3; i++) begin
      giveBeat();
      applyStimulus(39);
    end
    giveBeat();
    applyStimulus(40);
    waitValid("hr150");
    checkOutput("hr_150", hr_input, 150);

    // Enable falling mid-division aborts it but holds the outputs
    giveBeat();
    applyStimulus(5);
    enable = 1'b0;
    applyStimulus(1);
    checkOutput("disable_busy", div_busy, 0);
    checkOutput("disable_hr_hold", hr_input, 150);
    applyStimulus(2);
    enable = 1'b1;
    applyStimulus(25);

    // A restart during division discards the 100 bpm result
    giveBeat();
    applyStimulus(59);
    giveBeat();
    applyStimulus(24);
    giveBeat();
    seen100 = 0; seen240 = 0;
    for (int i = 0; i < 200; i++) begin
      applyStimulus(1);
      if (valid_input && hr_input == 8'd100) seen100 = 1;
      if (valid_input && hr_input == 8'd240) seen240 = 1;
    end
    checkOutput("no_100_bpm", seen100, 0);
    checkOutput("saw_240_bpm", seen240, 1);

    // Random traffic
    for (int i = 0; i < 5000; i++) begin
      rst = ($urandom_range(0, 1999) == 0);
      if (enable && $urandom_range(0, 499) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(0, 9) == 0) enable = 1'b1;
      step_pulse = ($urandom_range(0, 9) == 0);
      beat_pulse = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 199) == 0) stride_cfg = 8'($urandom_range(0, 255));
      applyStimulus(1);
    end
    rst = 1'b0; enable = 1'b1; step_pulse = 1'b0; beat_pulse = 1'b0;
    applyStimulus(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
